// File: rtl/bcd_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} dd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE       = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the next
// left shift carries correctly into the following decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? digit_in + BCD_ADJ_ADD : digit_in;

endmodule

// File: rtl/bin_to_bcd_dd.sv
// Sequential double-dabble converter: one input bit per clock, start/busy/done
// handshake, result and overflow flag held until the next conversion completes.
module bin_to_bcd_dd
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 12,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    overflow
);

  localparam int OUT_W = 4 * BCD_DIGITS;
  localparam int SCR_W = 4 * (BCD_DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  dd_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [BIN_W-1:0] shift_reg;
  logic [BIN_W-1:0] shift_shf;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_adj;
  logic [SCR_W-1:0] scratch_shf;
  logic             last_iter;
  logic             load;

  // Collapse an out-of-range result to all nines; the extra top digit is the
  // only place a too-large input can show up.
  function automatic logic [OUT_W-1:0] sat_bcd(input logic [SCR_W-1:0] s);
    if (s[SCR_W-1 -: 4] != 4'd0)
      return {BCD_DIGITS{BCD_NINE}};
    return s[OUT_W-1:0];
  endfunction

  for (genvar g = 0; g < BCD_DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  assign {scratch_shf, shift_shf} = {scratch_adj, shift_reg} << 1;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_iter = (cnt_inc == CNT_W'(BIN_W));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (last_iter)
          state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on the final shift edge, so they are already valid
  // during the DONE cycle and never change mid-conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shift_reg <= bin_in;
        scratch   <= '0;
        cnt       <= '0;
      end else if (state == SHIFT) begin
        shift_reg <= shift_shf;
        scratch   <= scratch_shf;
        cnt       <= cnt_inc;
        if (last_iter) begin
          bcd_out  <= sat_bcd(scratch_shf);
          overflow <= (scratch_shf[SCR_W-1 -: 4] != 4'd0);
        end
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
